mem_port_arbiter: RTL and testbench

Shares one single-ported, pipelined memory port between the instruction-fetch requester and the data (load/store) requester of the RV32I core. Request mux and response routing are combinational. An owner FIFO records who issued each accepted request so that in-order responses return to the right requester. Data requests have fixed priority over fetch, with an optional starvation guard; a denied fetch request stalls the fetch stage through its normal stall input.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_owner_fifo.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Types shared by the memory port arbiter and its owner FIFO.
//   owner_e     : which requester issued a transfer (0 = fetch, 1 = data)
//   arb_state_e : arbiter lock state (idle, locked on fetch, locked on data)
//   mem_req_t   : request payload carried by both requester ports and the
//                 memory port
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD_IF = 2'd1,
      ST_HOLD_D  = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// ---------------------------------------------------------------------------
// owner_fifo
// Records the owner bit of each accepted memory request so that in-order
// responses can be routed back to the requester that issued them.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_bit  : push one owner bit
//   i_pop          : pop the head entry
//   o_head         : owner bit at the head
//   o_full/o_empty : occupancy flags
//   o_count        : number of valid entries (0..DEPTH)
// Push while full and pop while empty are ignored.
// ---------------------------------------------------------------------------
module owner_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_bit,
   input  logic                       i_pop,
   output logic                       o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = DEPTH[AW:0];

   logic [DEPTH-1:0] r_bits;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == C_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_bits[r_rptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bits  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_bits[r_wptr] <= i_bit;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one pipelined memory port between instruction fetch (if_*) and the
// load/store unit (d_*). Data has fixed priority; a request that is selected
// but not granted locks the mux on that requester until it is granted.
// Responses are routed through an owner FIFO.
//   clk, rst_i                 : clock, synchronous active-high reset
//   if_req_i/if_addr_i         : fetch request        -> if_gnt_o
//   if_rvalid_o/if_rdata_o     : fetch response
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i : data request -> d_gnt_o
//   d_rvalid_o/d_rdata_o       : data response (writes included)
//   mem_req_o..mem_wdata_o     : memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i : memory accept, in-order response
//   resp_err_o                 : sticky, response with no outstanding owner
// Build option: ARB_STARVE_GUARD_EN adds a fetch starvation counter that
// forces fetch to win idle arbitration after STARVE_LIMIT denied cycles.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_be_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_err_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CW-1:0] C_MAX = MAX_OUTSTANDING[CW-1:0];

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   owner_e     w_sel;
   logic       w_sel_req;
   logic       w_issuable;
   logic       w_xfer;
   logic       w_pop;
   logic       w_force_if;
   logic       w_head;
   logic       w_full;
   logic       w_empty;
   logic [CW-1:0] w_count;
   logic       r_resp_err;
   mem_req_t   w_if_req;
   mem_req_t   w_d_req;
   mem_req_t   w_mem_req;

   // Fetch is always a full-word read.
   assign w_if_req = '{we: 1'b0, be: 4'hF, addr: if_addr_i, wdata: 32'h0};
   assign w_d_req  = '{we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] C_LIM = SW'(STARVE_LIMIT);

   logic [SW-1:0] r_starve_cnt;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_starve_cnt <= '0;
      end else if (if_gnt_o) begin
         r_starve_cnt <= '0;
      end else if (if_req_i && (r_starve_cnt != C_LIM)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   assign w_force_if = (r_starve_cnt == C_LIM);
`else
   assign w_force_if = 1'b0;
`endif

   // Selection: locked in HOLD states, priority arbitration in IDLE.
   always_comb begin
      w_sel     = OWN_D;
      w_sel_req = 1'b0;
      case (r_state)
         ST_HOLD_IF: begin
            w_sel     = OWN_IF;
            w_sel_req = if_req_i;
         end
         ST_HOLD_D: begin
            w_sel     = OWN_D;
            w_sel_req = d_req_i;
         end
         default: begin
            w_sel     = (d_req_i && !(w_force_if && if_req_i)) ? OWN_D : OWN_IF;
            w_sel_req = d_req_i | if_req_i;
         end
      endcase
   end

   // Uses the registered count: a same-cycle pop frees the slot next cycle.
   assign w_issuable = (w_count < C_MAX);
   assign mem_req_o  = w_issuable & w_sel_req;
   assign w_xfer     = mem_req_o & mem_gnt_i;
   assign if_gnt_o   = w_xfer & (w_sel == OWN_IF);
   assign d_gnt_o    = w_xfer & (w_sel == OWN_D);

   assign w_mem_req   = !mem_req_o ? '0 : ((w_sel == OWN_D) ? w_d_req : w_if_req);
   assign mem_we_o    = w_mem_req.we;
   assign mem_be_o    = w_mem_req.be;
   assign mem_addr_o  = w_mem_req.addr;
   assign mem_wdata_o = w_mem_req.wdata;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (mem_req_o && !mem_gnt_i) begin
               w_state_nxt = (w_sel == OWN_D) ? ST_HOLD_D : ST_HOLD_IF;
            end
         end
         default: begin
            // A withdrawn request also releases the lock so the port cannot
            // stay wedged on a requester that gave up.
            if (w_xfer || !w_sel_req) begin
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_resp_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (mem_rvalid_i && w_empty) begin
            r_resp_err <= 1'b1;
         end
      end
   end

   assign w_pop       = mem_rvalid_i & ~w_empty;
   assign if_rvalid_o = w_pop & (owner_e'(w_head) == OWN_IF);
   assign d_rvalid_o  = w_pop & (owner_e'(w_head) == OWN_D);
   assign if_rdata_o  = mem_rdata_i;
   assign d_rdata_o   = mem_rdata_i;
   assign resp_err_o  = r_resp_err;

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .i_clk   (clk),
      .i_rst   (rst_i),
      .i_push  (w_xfer & ~w_full),
      .i_bit   (w_sel),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus for mem_port_arbiter. Expected grants and responses are
// queued by the stimulus; a negedge monitor pops and compares them whenever
// the DUT asserts a gnt or rvalid output.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_gnt_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        resp_err_o;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .MAX_OUTSTANDING (2),
      .STARVE_LIMIT    (4)
   ) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_be_i       (d_be_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_gnt_o      (d_gnt_o),
      .d_rvalid_o   (d_rvalid_o),
      .d_rdata_o    (d_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .resp_err_o   (resp_err_o)
   );

   typedef struct {
      logic        is_d;
      logic [31:0] val;
   } exp_t;

   exp_t q_gnt[$];
   exp_t q_rsp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic d, input logic [31:0] v);
      exp_t e;
      e.is_d = d;
      e.val  = v;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every grant / response the DUT presents must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (if_gnt_o || d_gnt_o) begin
         if (q_gnt.size() == 0) begin
            check("gnt_unexpected", {30'd0, if_gnt_o, d_gnt_o}, 32'd0);
         end else begin
            e = q_gnt.pop_front();
            check("gnt_owner", {30'd0, if_gnt_o, d_gnt_o}, e.is_d ? 32'd1 : 32'd2);
            check("gnt_addr", mem_addr_o, e.val);
         end
      end
      if (if_rvalid_o || d_rvalid_o) begin
         if (q_rsp.size() == 0) begin
            check("rsp_unexpected", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
         end else begin
            e = q_rsp.pop_front();
            check("rsp_owner", {30'd0, if_rvalid_o, d_rvalid_o}, e.is_d ? 32'd1 : 32'd2);
            check("rsp_data", e.is_d ? d_rdata_o : if_rdata_o, e.val);
         end
      end
   end

   initial begin
      logic prev_d;
      logic exp_d;

      rst_i = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = '0; d_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      step();
      step();
      @(negedge clk);
      check("reset_outs", {26'd0, mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, resp_err_o}, 32'd0);
      check("reset_addr", mem_addr_o, 32'd0);
      step();
      rst_i = 1'b0;

      // Fetch alone: 0x0, 0x4, 0x8, one-cycle response latency.
      mem_gnt_i = 1'b1;
      if_req_i = 1'b1; if_addr_i = 32'h0;
      q_gnt.push_back(mk(1'b0, 32'h0));
      step();
      if_addr_i = 32'h4; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000;
      q_gnt.push_back(mk(1'b0, 32'h4));
      q_rsp.push_back(mk(1'b0, 32'h1000));
      step();
      if_addr_i = 32'h8; mem_rdata_i = 32'h1004;
      q_gnt.push_back(mk(1'b0, 32'h8));
      q_rsp.push_back(mk(1'b0, 32'h1004));
      step();
      if_req_i = 1'b0; mem_rdata_i = 32'h1008;
      q_rsp.push_back(mk(1'b0, 32'h1008));
      step();
      mem_rvalid_i = 1'b0;
      step();

      // Simultaneous fetch 0x10 and load 0x100: data first, then fetch.
      if_req_i = 1'b1; if_addr_i = 32'h10;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h100;
      q_gnt.push_back(mk(1'b1, 32'h100));
      step();
      d_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA;
      q_gnt.push_back(mk(1'b0, 32'h10));
      q_rsp.push_back(mk(1'b1, 32'hAAAA));
      step();
      if_req_i = 1'b0; mem_rdata_i = 32'hBBBB;
      q_rsp.push_back(mk(1'b0, 32'hBBBB));
      step();
      mem_rvalid_i = 1'b0;
      step();

      // Data store held off by mem_gnt_i=0 for 3 cycles; fetch raises meanwhile.
      mem_gnt_i = 1'b0;
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3; d_addr_i = 32'h200; d_wdata_i = 32'h55;
      @(negedge clk);
      check("hold_req", {31'd0, mem_req_o}, 32'd1);
      check("hold_addr0", mem_addr_o, 32'h200);
      step();
      if_req_i = 1'b1; if_addr_i = 32'h20;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("hold_addr", mem_addr_o, 32'h200);
         check("hold_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h13);
         step();
      end
      mem_gnt_i = 1'b1;
      q_gnt.push_back(mk(1'b1, 32'h200));
      @(negedge clk);
      check("hold_wdata", mem_wdata_o, 32'h55);
      step();
      d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'hF;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
      q_gnt.push_back(mk(1'b0, 32'h20));
      q_rsp.push_back(mk(1'b1, 32'h0));
      step();
      if_req_i = 1'b0; mem_rdata_i = 32'h77;
      q_rsp.push_back(mk(1'b0, 32'h77));
      step();
      mem_rvalid_i = 1'b0;
      step();

      // Outstanding limit of 2: third request blocked until a response pops.
      d_req_i = 1'b1; d_addr_i = 32'h300;
      q_gnt.push_back(mk(1'b1, 32'h300));
      step();
      d_addr_i = 32'h304;
      q_gnt.push_back(mk(1'b1, 32'h304));
      step();
      d_addr_i = 32'h308;
      @(negedge clk);
      check("full_no_req", {30'd0, mem_req_o, d_gnt_o}, 32'd0);
      step();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
      q_rsp.push_back(mk(1'b1, 32'h11));
      @(negedge clk);
      check("full_pop_same_cycle", {31'd0, mem_req_o}, 32'd0);
      step();
      mem_rvalid_i = 1'b0;
      q_gnt.push_back(mk(1'b1, 32'h308));
      @(negedge clk);
      check("resume_req", {31'd0, mem_req_o}, 32'd1);
      step();
      d_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22;
      q_rsp.push_back(mk(1'b1, 32'h22));
      step();
      mem_rdata_i = 32'h33;
      q_rsp.push_back(mk(1'b1, 32'h33));
      step();
      mem_rvalid_i = 1'b0;
      step();

      // Response with nothing outstanding: sticky error until reset.
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD;
      @(negedge clk);
      check("err_before", {31'd0, resp_err_o}, 32'd0);
      check("err_no_route", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
      step();
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      check("err_set", {31'd0, resp_err_o}, 32'd1);
      step(); step(); step();
      @(negedge clk);
      check("err_sticky", {31'd0, resp_err_o}, 32'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk);
      check("err_cleared", {31'd0, resp_err_o}, 32'd0);
      step();

      // Data requesting every cycle alongside fetch.
      prev_d = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         if_req_i = 1'b1; if_addr_i = 32'h40;
         d_req_i = 1'b1; d_addr_i = 32'h400 + 32'(4 * k);
         exp_d = GUARD ? (k != 5) : 1'b1;
         q_gnt.push_back(mk(exp_d, exp_d ? d_addr_i : 32'h40));
         if (k > 1) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5000 + 32'(k);
            q_rsp.push_back(mk(prev_d, mem_rdata_i));
         end
         prev_d = exp_d;
         step();
      end
      if_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5007;
      q_rsp.push_back(mk(prev_d, 32'h5007));
      step();
      mem_rvalid_i = 1'b0;
      step();

      // Reset with a request outstanding: the late response is orphaned.
      mem_gnt_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h500;
      q_gnt.push_back(mk(1'b1, 32'h500));
      step();
      d_req_i = 1'b0; mem_gnt_i = 1'b0; rst_i = 1'b1;
      step();
      rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
      @(negedge clk);
      check("stale_no_route", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
      step();
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      check("stale_err", {31'd0, resp_err_o}, 32'd1);
      step();

      check("gnt_queue_drained", 32'(q_gnt.size()), 32'd0);
      check("rsp_queue_drained", 32'(q_rsp.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
